muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative divide sequencer for the execute stage. It accepts DIV/DIVU requests from EX, runs a 32-step restoring division on operand magnitudes and stalls the pipeline while busy. It presents quotient (LO) and remainder (HI) with a one-cycle `ready_o` pulse for the HI/LO write port. Multiplies stay in the combinational ALU; this block owns only the multi-cycle divide path and its stall/annul handshake.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `clk` in 1: rising-edge clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start_i` in 1: EX holds a DIV/DIVU. Held stable by the stalled EX stage.
- `signed_i` in 1: 1 = DIV (signed), 0 = DIVU. Sampled with `start_i` in IDLE.
- `dividend_i` in 32: rs value. Sampled in IDLE.
- `divisor_i` in 32: rt value. Sampled in IDLE.
- `annul_i` in 1: exception/flush. Aborts any operation.
- `stall_o` out 1: hold IF/ID/EX.
- `ready_o` out 1: result valid this cycle; single-cycle pulse.
- `hi_o` out 32: remainder, registered.
- `lo_o` out 32: quotient, registered.

## Operation
States are IDLE, ZERO, RUN and DONE.

- **IDLE**
  - If `start_i & ~annul_i`: latch `signed_i`, the operand magnitudes (two's-complement negate if signed and negative) and the sign flags.
  - Next state: ZERO if `divisor_i==0`, else RUN with the step counter at 0.
- **ZERO**
  - Result is quotient = 32'hFFFF_FFFF, remainder = original `dividend_i`.
  - Next state: DONE.
- **RUN**
  - Each cycle: `{rem,quo} <<= 1`, then trial = rem − |divisor|.
  - If trial ≥ 0: rem = trial and quo[0] = 1.
  - The counter increments; after step 31 (32 steps total) go to DONE.
- **DONE**
  - `ready_o`=1.
  - For signed ops, quotient is negated if the dividend and divisor signs differ, and remainder is negated if the dividend was negative.
  - Next state: IDLE unconditionally. No back-to-back restart from DONE.
- **Signed corner case:** 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0. This is the natural result and needs no special case.
- **`stall_o` decode:** `(IDLE & start_i & ~annul_i) | ZERO | RUN`. It is combinational from state and inputs, and 0 in DONE so EX advances on the ready cycle.
- **Annul:** `annul_i` in any state forces IDLE on the next edge. `ready_o` is not asserted, `hi_o`/`lo_o` are unchanged, and `stall_o` is 0 in that cycle.
- **Output hold:** `hi_o`/`lo_o` load only on entry to DONE and hold their value otherwise.

## Timing
- Reset values:
  - State is IDLE, `ready_o`=0, `hi_o`=0, `lo_o`=0, counter 0.
  - `stall_o`=0 while reset is held.
- Normal latency: start sampled at edge E0, RUN on E1..E32, DONE visible after E32.
  - `ready_o` is high in the cycle after E32 (33 cycles of stall), then IDLE.
- Divide by zero: ZERO for 1 cycle, DONE the next cycle, so `ready_o` is high in the 2nd cycle after the sample edge.
- `ready_o` is registered and high for exactly one cycle per completed operation.
- Reset asserted mid-RUN: immediate return to the reset values, with no ready pulse.
- `annul_i` and the final RUN step on the same edge: annul wins, giving IDLE with no ready pulse.

## Configuration
- `DIV_EARLY_OUT_EN`
  - **Defined:** in IDLE, if the divisor is nonzero and |dividend| < |divisor| (unsigned compare of magnitudes), go directly to DONE with quotient 0 and remainder = original `dividend_i`, skipping RUN. `ready_o` is high 1 cycle after the sample edge.
  - **Undefined:** every nonzero-divisor operation takes the full 32 RUN steps; there is no magnitude comparator.

## Test plan
- DIVU 100 / 7: `stall_o` high for 33 cycles, then `ready_o` pulse with lo=14, hi=2.
- DIV −7 (0xFFFF_FFF9) / 2: lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1). Also 0x8000_0000 / −1: lo=0x8000_0000, hi=0.
- DIVU 5 / 0: lo=0xFFFF_FFFF, hi=5, `ready_o` in the 2nd cycle after start.
- DIVU 3 / 10: lo=0, hi=3.
  - With `DIV_EARLY_OUT_EN`, ready 1 cycle after start.
  - Without it, ready after 33 cycles.
- `annul_i` pulsed at RUN step 10: IDLE next cycle, no `ready_o`, `hi_o`/`lo_o` keep the previous result. A new start then completes correctly.
- `resetn` low mid-RUN: all outputs 0 immediately. After release with `start_i`=0, the block stays idle with `stall_o`=0.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative 32-step restoring divider for DIV/DIVU with pipeline stall and annul.
// Optional DIV_EARLY_OUT_EN: skip RUN when |dividend| < |divisor|.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

    state_t           state_q;
    logic             sign_q, dn_q, ds_q, ready_q;
    logic [4:0]       cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, hi_q, lo_q;

    logic [WIDTH-1:0] dvd_mag, dvs_mag, rem_d, quo_d, lo_fix, hi_fix;
    logic [WIDTH:0]   rem_sh;
    logic             ge;

    always_comb begin
        dvd_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
        dvs_mag = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
        // rem_sh < 2*|divisor|, so a successful trial always fits in WIDTH bits
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, dvs_q});
        rem_d   = ge ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ge};
        lo_fix  = (sign_q && (dn_q ^ ds_q)) ? -quo_d : quo_d;
        hi_fix  = (sign_q && dn_q) ? -rem_d : rem_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            dn_q    <= 1'b0;
            ds_q    <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            if (annul_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (start_i) begin
                        sign_q <= signed_i;
                        dn_q   <= dividend_i[WIDTH-1];
                        ds_q   <= divisor_i[WIDTH-1];
                        rem_q  <= '0;
                        quo_q  <= dvd_mag;
                        dvs_q  <= dvs_mag;
                        cnt_q  <= '0;
                        if (divisor_i == '0) begin
                            state_q <= ZERO;
`ifdef DIV_EARLY_OUT_EN
                        end else if (dvd_mag < dvs_mag) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            lo_q    <= '0;
                            hi_q    <= dividend_i;
`endif
                        end else begin
                            state_q <= RUN;
                        end
                    end
                    ZERO: begin
                        // quo_q holds |dividend|; re-applying the sign restores the original
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        lo_q    <= '1;
                        hi_q    <= (sign_q && dn_q) ? -quo_q : quo_q;
                    end
                    RUN: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            lo_q    <= lo_fix;
                            hi_q    <= hi_fix;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign stall_o = resetn && !annul_i &&
                     (((state_q == IDLE) && start_i) || (state_q == ZERO) || (state_q == RUN));
    assign ready_o = ready_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: latency/arith model plus directed vectors.
// Honours DIV_EARLY_OUT_EN in the expected latency.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        annul_i = 1'b0;
    logic        stall_o, ready_o;
    logic [31:0] hi_o, lo_o;

    int n_cmp = 0;
    int n_fail = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .annul_i(annul_i),
        .stall_o(stall_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (b == 0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`else
        if (ma == mb && ma == 0) return 0;
`endif
        return 33;
    endfunction

    // Model: edges remaining until the result register loads
    bit          m_busy = 1'b0, m_ready = 1'b0, was_done = 1'b0;
    int          m_left = 0, m_l = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_busy = 1'b0; m_ready = 1'b0; m_left = 0; m_hi = '0; m_lo = '0;
        end else begin
            was_done = m_ready;
            m_ready  = 1'b0;
            if (annul_i) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_ready = 1'b1; {m_hi, m_lo} = m_res;
                end
            end else if (!was_done && start_i) begin
                m_res = ref_div(signed_i, dividend_i, divisor_i);
                m_l   = ref_lat(signed_i, dividend_i, divisor_i);
                if (m_l == 1) begin
                    m_ready = 1'b1; {m_hi, m_lo} = m_res;
                end else begin
                    m_busy = 1'b1; m_left = m_l - 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("ready", 32'(ready_o), 32'(m_ready));
        check("stall", 32'(stall_o),
              32'(resetn && !annul_i && ((!m_busy && !m_ready && start_i) || m_busy)));
        check("hi", hi_o, m_hi);
        check("lo", lo_o, m_lo);
    end

    task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input int elat);
        logic [63:0] r;
        int n, st;
        r = ref_div(s, a, b);
        check("model_lo", r[31:0], elo);
        check("model_hi", r[63:32], ehi);
        check("model_lat", 32'(ref_lat(s, a, b)), 32'(elat));
        @(posedge clk); #2;
        start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
        n = 0; st = 0;
        @(negedge clk);
        if (stall_o) st++;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (stall_o) st++;
            if (ready_o) break;
        end
        check("latency", 32'(n), 32'(elat));
        check("stall_cycles", 32'(st), 32'(elat));
        check("op_lo", lo_o, elo);
        check("op_hi", hi_o, ehi);
        @(posedge clk); #2 start_i = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic count_ready(input int cycles, output int rc);
        rc = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ready_o) rc++;
        end
    endtask

    int rc;

    initial begin
        #1;
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk); #2;

        do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33);
        do_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2);
`ifdef DIV_EARLY_OUT_EN
        do_op(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1);
        do_op(1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, 1);
`else
        do_op(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 33);
        do_op(1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, 33);
`endif
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
        do_op(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 33);
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
        do_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 2);
        do_op(1'b0, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 33);

        // Annul partway through RUN: no ready, previous result retained
        @(posedge clk); #2;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
        repeat (11) @(posedge clk);
        #2 annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #2 annul_i = 1'b0;
        count_ready(40, rc);
        check("annul_mid_no_ready", 32'(rc), 32'd0);
        check("annul_mid_hold_lo", lo_o, 32'h2AAA_AAAA);
        check("annul_mid_hold_hi", hi_o, 32'd2);
        do_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

        // Annul coinciding with the final RUN step
        @(posedge clk); #2;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd7;
        repeat (32) @(posedge clk);
        #2 annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #2 annul_i = 1'b0;
        count_ready(5, rc);
        check("annul_last_no_ready", 32'(rc), 32'd0);
        check("annul_last_hold_lo", lo_o, 32'd333);

        // Reset asserted mid-RUN
        @(posedge clk); #2;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd77; divisor_i = 32'd5;
        repeat (16) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_ready", 32'(ready_o), 32'd0);
        check("midrst_stall", 32'(stall_o), 32'd0);
        check("midrst_hi", hi_o, 32'd0);
        check("midrst_lo", lo_o, 32'd0);
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        count_ready(4, rc);
        check("postrst_no_ready", 32'(rc), 32'd0);
        check("postrst_stall", 32'(stall_o), 32'd0);
        do_op(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
